// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency stream loader.
// Holds the loader state encoding and the per-channel slice width used for packing.
package freq_pkg;

  localparam int CH_SLICE_W = 15;
  localparam int NUM_CH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_busy_state(input state_e st);
    return (st == ST_RD) || (st == ST_WR);
  endfunction

endpackage

// File: rtl/freq_addr_gen.sv
// Next ROM address with wrap from DEPTH-1 back to 0 (DEPTH need not be a power of two).
module freq_addr_gen #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] next_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // increment with explicit wrap at the last ROM entry
  always_comb begin
    next_addr = '0;
    if (cur_addr == LAST_ADDR) begin
      next_addr = '0;
    end else begin
      next_addr = cur_addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/freq_stream_loader.sv
// Streams a window of multi-channel frequency words from ROM into NUM_CH FIFOs.
// Optional FREQ_LOADER_ZERO_TERM_EN: an all-zero ROM word ends the load without being written.
module freq_stream_loader
  import freq_pkg::*;
#(
  parameter int FREQ_W = CH_SLICE_W,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          length,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [NUM_CH*FREQ_W-1:0] rom_data,
  input  logic [NUM_CH-1:0]        fifo_full,
  output logic                     wr_en,
  output logic [NUM_CH*FREQ_W-1:0] freq_out,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          loaded
);

  localparam int DATA_W = NUM_CH * FREQ_W;
  localparam logic [ADDR_W:0] ONE_L = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_r;
  state_e              state_nx_s;
  logic                accept_s;
  logic                write_s;
  logic                marker_s;
  logic [ADDR_W:0]     length_r;
  logic [ADDR_W:0]     loaded_r;
  logic [ADDR_W:0]     loaded_inc_s;
  logic [ADDR_W-1:0]   rom_addr_r;
  logic [ADDR_W-1:0]   addr_nx_s;
  logic                wr_en_r;
  logic [DATA_W-1:0]   freq_out_r;
  logic                busy_r;
  logic                done_r;

  freq_addr_gen #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .cur_addr  (rom_addr_r),
    .next_addr (addr_nx_s)
  );

  assign loaded_inc_s = loaded_r + ONE_L;

`ifdef FREQ_LOADER_ZERO_TERM_EN
  assign marker_s = (rom_data == {DATA_W{1'b0}});
`else
  assign marker_s = 1'b0;
`endif

  // next-state and per-cycle control decode; abort outranks marker, full and write
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    write_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (length == {(ADDR_W+1){1'b0}}) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RD;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (abort) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WR;
        end
      end
      ST_WR: begin
        if (abort) begin
          state_nx_s = ST_DONE;
        end else if (marker_s) begin
          state_nx_s = ST_DONE;
        end else if (|fifo_full) begin
          state_nx_s = ST_WR;
        end else begin
          write_s = 1'b1;
          if (loaded_inc_s == length_r) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RD;
          end
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // datapath: the address register already points at the next word once a write lands,
  // so the following RD cycle presents it to the ROM without extra logic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      length_r   <= {(ADDR_W+1){1'b0}};
      loaded_r   <= {(ADDR_W+1){1'b0}};
      rom_addr_r <= {ADDR_W{1'b0}};
      wr_en_r    <= 1'b0;
      freq_out_r <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      wr_en_r <= write_s;
      busy_r  <= is_busy_state(state_nx_s);
      done_r  <= (state_r == ST_DONE);
      if (accept_s) begin
        length_r   <= length;
        loaded_r   <= {(ADDR_W+1){1'b0}};
        rom_addr_r <= base_addr;
      end else if (write_s) begin
        loaded_r   <= loaded_inc_s;
        rom_addr_r <= addr_nx_s;
      end else begin
        loaded_r   <= loaded_r;
        rom_addr_r <= rom_addr_r;
      end
      if (write_s) begin
        freq_out_r <= rom_data;
      end else begin
        freq_out_r <= freq_out_r;
      end
    end
  end

  assign rom_addr = rom_addr_r;
  assign wr_en    = wr_en_r;
  assign freq_out = freq_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign loaded   = loaded_r;

endmodule

// File: tb/tb_freq_stream_loader.sv
// Self-checking bench for freq_stream_loader: vector table plus scoreboard of expected FIFO words.
module tb_freq_stream_loader;

  localparam int FREQ_W = 15;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = NUM_CH * FREQ_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [NUM_CH-1:0] fifo_full = '0;
  logic              wr_en;
  logic [DATA_W-1:0] freq_out;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   loaded;

  freq_stream_loader #(
    .FREQ_W (FREQ_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .freq_out  (freq_out),
    .busy      (busy),
    .done      (done),
    .loaded    (loaded)
  );

  always #5 clk = ~clk;

  // synchronous ROM model: data one cycle after address
  logic [DATA_W-1:0] rom_mem [DEPTH];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  function automatic logic [DATA_W-1:0] rom_word(input int i);
    return {FREQ_W'(i + 100), FREQ_W'(i + 200)};
  endfunction

  typedef struct {
    int       base;
    int       len;
    int       stall_after;
    int       stall_cyc;
    logic [1:0] mask;
    int       abort_after;
    int       abort_dly;
    bit       abort_at_start;
    int       restart_cyc;
    int       zero_off;
    int       exp_writes;
    int       exp_first;
    int       exp_done;
  } vec_t;

  function automatic vec_t mk(input int base, input int len, input int sa, input int sc,
                              input logic [1:0] m, input int aa, input int ad, input bit as_,
                              input int rc, input int zo, input int ew, input int ef, input int ed);
    vec_t v;
    v.base = base; v.len = len; v.stall_after = sa; v.stall_cyc = sc; v.mask = m;
    v.abort_after = aa; v.abort_dly = ad; v.abort_at_start = as_; v.restart_cyc = rc;
    v.zero_off = zo; v.exp_writes = ew; v.exp_first = ef; v.exp_done = ed;
    return v;
  endfunction

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q [$];
  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, writes, dones, done_cyc, first_cyc, full_left, abort_wait;
    bit stall_armed, abort_armed;
    logic [1:0] full_prev;
    logic [DATA_W-1:0] exp_w;
    string tag;
    tag = $sformatf("v%0d", idx);
    if (v.zero_off >= 0) rom_mem[(v.base + v.zero_off) % DEPTH] = '0;
    for (int j = 0; j < v.exp_writes; j++) exp_q.push_back(rom_mem[(v.base + j) % DEPTH]);
    @(negedge clk);
    base_addr = ADDR_W'(v.base);
    length = (ADDR_W + 1)'(v.len);
    start = 1'b1;
    abort = v.abort_at_start;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cyc = 0; writes = 0; dones = 0; done_cyc = -1; first_cyc = -1;
    full_left = 0; abort_wait = -1; stall_armed = 1'b0; abort_armed = 1'b0; full_prev = 2'b00;
    while (1) begin
      if (wr_en) begin
        check({tag, " full_at_write"}, 64'(full_prev), 64'd0);
        if (first_cyc < 0) first_cyc = cyc;
        writes++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL %s extra_write: got data %0h expected no write", tag, freq_out);
        end else begin
          exp_w = exp_q.pop_front();
          check({tag, " freq_out"}, 64'(freq_out), 64'(exp_w));
        end
      end
      if (cyc == 1) check({tag, " busy_c1"}, 64'(busy), 64'(v.len != 0));
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (dones > 0 || cyc >= 200) break;
      if (!stall_armed && v.stall_after >= 0 && writes == v.stall_after) begin
        stall_armed = 1'b1;
        full_left = v.stall_cyc;
      end
      if (!abort_armed && v.abort_after >= 0 && writes == v.abort_after) begin
        abort_armed = 1'b1;
        abort_wait = v.abort_dly;
      end
      fifo_full = (full_left > 0) ? v.mask : 2'b00;
      if (full_left > 0) full_left--;
      abort = 1'b0;
      if (abort_wait == 0) begin
        abort = 1'b1;
        abort_wait = -1;
      end else if (abort_wait > 0) begin
        abort_wait--;
      end
      start = (cyc + 1 == v.restart_cyc);
      if (start) begin
        base_addr = ADDR_W'(9);
        length = (ADDR_W + 1)'(1);
      end
      full_prev = fifo_full;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    fifo_full = 2'b00;
    check({tag, " done_count"}, 64'(dones), 64'd1);
    check({tag, " writes"}, 64'(writes), 64'(v.exp_writes));
    check({tag, " first_write_cyc"}, 64'(first_cyc), 64'(v.exp_first));
    check({tag, " done_cyc"}, 64'(done_cyc), 64'(v.exp_done));
    check({tag, " loaded"}, 64'(loaded), 64'(v.exp_writes));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " pending_words"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check({tag, " done_pulse_end"}, 64'(done), 64'd0);
    if (v.zero_off >= 0) rom_mem[(v.base + v.zero_off) % DEPTH] = rom_word((v.base + v.zero_off) % DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = rom_word(i);
    //          base len  sa sc mask   aa ad st rc  zo  ew ef  ed
    vecs[0] = mk(0,  4,  -1, 0, 2'b00, -1, 0, 0, 3, -1, 4, 2,  9);
    vecs[1] = mk(0,  3,   1, 5, 2'b10, -1, 0, 0, -1, -1, 3, 2, 11);
    vecs[2] = mk(14, 4,  -1, 0, 2'b00, -1, 0, 0, -1, -1, 4, 2,  9);
    vecs[3] = mk(0,  10, -1, 0, 2'b00,  2, 1, 0, -1, -1, 2, 2,  7);
    vecs[4] = mk(5,  10, -1, 0, 2'b00,  2, 0, 0, -1, -1, 2, 2,  6);
    vecs[5] = mk(3,  0,  -1, 0, 2'b00, -1, 0, 0, -1, -1, 0, -1, 1);
`ifdef FREQ_LOADER_ZERO_TERM_EN
    vecs[6] = mk(0,  8,  -1, 0, 2'b00, -1, 0, 0, -1, 3,  3, 2,  9);
`else
    vecs[6] = mk(0,  8,  -1, 0, 2'b00, -1, 0, 0, -1, 3,  8, 2, 17);
`endif
    vecs[7] = mk(15, 2,   0, 3, 2'b01, -1, 0, 0, -1, -1, 2, 4,  7);
    vecs[8] = mk(0,  5,   1, 6, 2'b11,  1, 3, 0, -1, -1, 1, 2,  7);
    vecs[9] = mk(2,  1,  -1, 0, 2'b00, -1, 0, 1, -1, -1, 1, 2,  3);

    repeat (2) @(negedge clk);
    check("rst rom_addr", 64'(rom_addr), 64'd0);
    check("rst wr_en", 64'(wr_en), 64'd0);
    check("rst freq_out", 64'(freq_out), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst loaded", 64'(loaded), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    // asynchronous reset right after a write, between clock edges
    @(negedge clk);
    base_addr = ADDR_W'(0);
    length = (ADDR_W + 1)'(6);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("arst pre wr_en", 64'(wr_en), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst wr_en", 64'(wr_en), 64'd0);
    check("arst freq_out", 64'(freq_out), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst loaded", 64'(loaded), 64'd0);
    check("arst rom_addr", 64'(rom_addr), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("arst no_done", 64'(done), 64'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("arst idle_no_done", 64'(done), 64'd0);
    run_vec(vecs[0], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_stream_loader.md
Name: freq_stream_loader

Overview:
Parametrised successor to the single-track frequency loader. On a start pulse it streams a window of note-frequency words from a multi-channel frequency ROM into NUM_CH parallel write-side FIFOs (song, reference, …) with one shared write strobe. It honours per-FIFO full backpressure, supports a programmable start address and length, and can be aborted. It sits between the frequency ROM and the scoring FIFOs in the scoring/display path.

Parameters:
FREQ_W, 15, width of one frequency word per channel
NUM_CH, 2, number of parallel frequency channels/FIFOs
DEPTH, 4096, ROM entries per channel
ADDR_W, $clog2(DEPTH), ROM address and length width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  single-cycle load request, sampled only in IDLE
abort  in  1  stop streaming, go to DONE without further writes
base_addr  in  ADDR_W  first ROM address, latched on accepted start
length  in  ADDR_W+1  words to load, latched on accepted start; 0 = none
rom_addr  out  ADDR_W  ROM read address
rom_data  in  NUM_CH*FREQ_W  ROM word, valid 1 cycle after rom_addr; channel k at bits [k*FREQ_W +: FREQ_W]
fifo_full  in  NUM_CH  full flag per destination FIFO
wr_en  out  1  common write strobe to all FIFOs
freq_out  out  NUM_CH*FREQ_W  write data, same packing as rom_data
busy  out  1  high in RD/WR
done  out  1  one-cycle pulse at end of load
loaded  out  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (rst=0, async): state IDLE; rom_addr=0, wr_en=0, freq_out=0, busy=0, done=0, loaded=0.
- States: IDLE, RD, WR, DONE (2-bit encoding).
- IDLE: start=1 -> latch base_addr/length, clear loaded; length=0 -> DONE, else -> RD. start ignored outside IDLE.
- RD: rom_addr = base + loaded (mod DEPTH, wraps at DEPTH-1 -> 0); -> WR.
- WR: rom_data valid. If any fifo_full bit set: wr_en=0, hold in WR, rom_addr held. Else wr_en=1, freq_out=rom_data, loaded+1; if loaded+1==length -> DONE, else -> RD.
- wr_en and freq_out registered together; wr_en high exactly one cycle per word; never asserted while the sampled fifo_full has any bit set.
- Latency: start sampled at cycle 0 -> first wr_en at cycle 2. Throughput 1 word per 2 cycles without stalls.
- abort=1 in RD or WR -> DONE next cycle; no write in that cycle; abort has priority over write and over full. abort in IDLE/DONE ignored.
- DONE: done=1 for one cycle, busy=0, -> IDLE. loaded holds until next accepted start.
- Simultaneous start+abort in IDLE: start accepted, abort ignored.
- Reset mid-load: immediate return to IDLE, no done pulse.

Optional Feature:
Macro FREQ_LOADER_ZERO_TERM_EN. Defined: in WR, if all NUM_CH channel words of rom_data equal 0 (end-of-song marker), the word is not written and the FSM goes to DONE; loaded excludes the marker. Undefined: zero words are written like any other; only length/abort end a load.

Decomposition:
- Shared package freq_pkg: FREQ_W default, state typedef/encodings (IDLE/RD/WR/DONE), the channel packing helper constant (channel slice width).
- No sub-module needed; optional sub-module freq_addr_gen (base+offset with DEPTH wrap) if reused by readback logic.

Test Plan:
- Basic: base_addr=0, length=4, ROM word i = {i+100, i+200}, no full -> 4 wr_en pulses at cycles 2,4,6,8; freq_out ch0=200..203, ch1=100..103; done at cycle 9; loaded=4.
- Backpressure: length=3, fifo_full=2'b10 held for 5 cycles during 2nd word -> wr_en stays low while full, word 2 written once after release, no drops/duplicates, loaded=3.
- Wrap: DEPTH=16, base_addr=14, length=4 -> rom_addr 14,15,0,1; 4 writes.
- Abort: length=10, abort at 3rd WR -> exactly 2 writes, done one cycle later, loaded=2; length=0 -> done at cycle 1, no wr_en.
- Async reset: assert rst=0 mid-stream between clock edges -> outputs zero immediately, no done; fresh start after release loads normally.
- FREQ_LOADER_ZERO_TERM_EN defined: all-zero word at offset 3, length=8 -> 3 writes, done, loaded=3; undefined -> 8 writes.
